fixed_point_subtractor: RTL and testbench

Pipelined sign-magnitude fixed-point subtractor computing c = a - b on N-bit operands. It is the inverse companion to the combinational sign-magnitude adder in the datapath and uses the same number format: bit N-1 is the sign, N-2:0 is the magnitude, and the binary point position is transparent to the arithmetic. It adds a valid/ready handshake on both sides, a two-stage pipeline with backpressure, saturation with an overflow flag, and negative-zero suppression, so it can sit directly in streaming datapaths.

---
 rtl/fixed_point_subtractor_if.sv | 24 ++
 rtl/fixed_point_subtractor.sv | 110 +++++++++++
 tb/tb_fixed_point_subtractor.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fixed_point_subtractor_if.sv
// Streaming operand/result bundle for the sign-magnitude subtractor.
// The slave side is the subtractor; the master side feeds operands and drains results.
interface fixed_point_subtractor_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, overflow
    );
endinterface

// File: rtl/fixed_point_subtractor.sv
// Pipelined sign-magnitude subtractor c = a - b with saturation and negative-zero suppression.
// Latency: 2 cycles (operand register, result register); 1 op/cycle while out_ready is high.
// Backpressure: holds up to two ops; in_ready depends only on out_ready and internal state.
module fixed_point_subtractor #(
    parameter int N = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    fixed_point_subtractor_if.slave io
);

    typedef struct packed {
        logic [N-2:0] ma;
        logic [N-2:0] mb;
        logic         sa;
        logic         sb;
        logic         same;
        logic         age;
    } s1_t;

    s1_t          s1_q;
    s1_t          s1_d;
    logic         s1_valid;
    logic         out_valid_q;
    logic [N-1:0] c_q;
    logic         ovf_q;

    logic         s2_free;
    logic         in_ready;
    logic         in_fire;
    logic         s1_move;

    logic [N-1:0] sum;
    logic [N-2:0] res_mag;
    logic         res_sign;
    logic         res_ovf;
    logic [N-1:0] res_c;

    // Handshake control: nothing here looks at in_valid to produce in_ready.
    assign s2_free  = !out_valid_q || io.out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign in_fire  = io.in_valid && in_ready;
    assign s1_move  = s1_valid && s2_free;

    // Subtraction is addition of b with its sign flipped.
    always_comb begin
        s1_d.ma   = io.a[N-2:0];
        s1_d.mb   = io.b[N-2:0];
        s1_d.sa   = io.a[N-1];
        s1_d.sb   = ~io.b[N-1];
        s1_d.same = (io.a[N-1] == ~io.b[N-1]);
        s1_d.age  = (io.a[N-2:0] >= io.b[N-2:0]);
    end

    always_comb begin
        sum      = {1'b0, s1_q.ma} + {1'b0, s1_q.mb};
        res_mag  = '0;
        res_sign = 1'b0;
        res_ovf  = 1'b0;
        if (s1_q.same) begin
            res_sign = s1_q.sa;
            if (sum[N-1]) begin
                res_mag = '1;
                res_ovf = 1'b1;
            end else begin
                res_mag = sum[N-2:0];
            end
        end else if (s1_q.age) begin
            res_mag  = s1_q.ma - s1_q.mb;
            res_sign = s1_q.sa;
        end else begin
            res_mag  = s1_q.mb - s1_q.ma;
            res_sign = s1_q.sb;
        end
        // A zero magnitude always leaves with a positive sign.
        res_c = {res_sign & (|res_mag), res_mag};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_q     <= s1_d;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
        end else if (s1_move) begin
            out_valid_q <= 1'b1;
            c_q         <= res_c;
            ovf_q       <= res_ovf;
        end else if (io.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid_q;
    assign io.c         = c_q;
    assign io.overflow  = ovf_q;

endmodule

// File: tb/tb_fixed_point_subtractor.sv
// Directed bench for fixed_point_subtractor with N=32; checks sit 1 time unit after the rising edge.
module tb_fixed_point_subtractor;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fixed_point_subtractor_if #(.N(32)) io ();

    fixed_point_subtractor #(.N(32)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] ST_A [6] = '{32'h0000_000A, 32'h7FFF_FFFF, 32'h0000_0001,
                                         32'h8000_0010, 32'h8000_0002, 32'h0000_0006};
    localparam logic [31:0] ST_B [6] = '{32'h0000_0003, 32'h8000_0001, 32'h0000_0002,
                                         32'h0000_0001, 32'h8000_0009, 32'h0000_0006};
    localparam logic [31:0] ST_C [6] = '{32'h0000_0007, 32'h7FFF_FFFF, 32'h8000_0001,
                                         32'h8000_0011, 32'h0000_0007, 32'h0000_0000};
    localparam logic        ST_O [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one op, confirm out_valid is still low one edge later, then check the result.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_c, input logic exp_o);
        io.a        = a;
        io.b        = b;
        io.in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, {31'b0, io.in_ready}, 32'd1);
        step();
        io.in_valid = 1'b0;
        check({tag, "_vld_early"}, {31'b0, io.out_valid}, 32'd0);
        step();
        check({tag, "_vld"}, {31'b0, io.out_valid}, 32'd1);
        check({tag, "_c"}, io.c, exp_c);
        check({tag, "_ovf"}, {31'b0, io.overflow}, {31'b0, exp_o});
        step();
    endtask

    initial begin
        int in_idx;
        int out_idx;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        io.in_valid  = 1'b0;
        io.a         = '0;
        io.b         = '0;
        io.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, io.out_valid}, 32'd0);
        check("rst_c", io.c, 32'd0);
        check("rst_ovf", {31'b0, io.overflow}, 32'd0);
        check("rst_in_ready", {31'b0, io.in_ready}, 32'd1);

        run_op("sub_pos",    32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0);
        run_op("sub_neg",    32'h0000_0003, 32'h0000_0005, 32'h8000_0002, 1'b0);
        run_op("neg_minus",  32'h8000_0003, 32'h0000_0005, 32'h8000_0008, 1'b0);
        run_op("zero_eq",    32'h8000_0004, 32'h8000_0004, 32'h0000_0000, 1'b0);
        run_op("negzero",    32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        run_op("sat_pos",    32'h7FFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF, 1'b1);
        run_op("sat_neg",    32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        run_op("max_noovf",  32'h7FFF_FFFE, 32'h8000_0001, 32'h7FFF_FFFF, 1'b0);
        run_op("zero_minus", 32'h0000_0000, 32'h0000_0007, 32'h8000_0007, 1'b0);

        // Six back-to-back ops with the consumer stalled on cycles 2..5.
        in_idx  = 0;
        out_idx = 0;
        for (int cyc = 0; cyc < 40 && out_idx < 6; cyc++) begin
            io.out_ready = !(cyc >= 2 && cyc <= 5);
            io.in_valid  = (in_idx < 6);
            if (in_idx < 6) begin
                io.a = ST_A[in_idx];
                io.b = ST_B[in_idx];
            end
            #1;
            check("stream_in_ready", {31'b0, io.in_ready},
                  {31'b0, ((in_idx - out_idx) < 2) || io.out_ready});
            if (io.out_valid) begin
                if (out_idx < 6) begin
                    check("stream_c", io.c, ST_C[out_idx]);
                    check("stream_ovf", {31'b0, io.overflow}, {31'b0, ST_O[out_idx]});
                end
                if (io.out_ready) out_idx++;
            end
            if (io.in_valid && io.in_ready) in_idx++;
            @(posedge clk);
            #1;
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        check("stream_accepted", in_idx, 32'd6);
        check("stream_emitted", out_idx, 32'd6);
        step();
        check("stream_drained", {31'b0, io.out_valid}, 32'd0);

        // Fill both stages, then reset mid-stream with in_valid still high.
        io.out_ready = 1'b0;
        io.in_valid  = 1'b1;
        io.a         = 32'h0000_0009;
        io.b         = 32'h0000_0001;
        step();
        io.a = 32'h0000_0002;
        step();
        check("full_vld", {31'b0, io.out_valid}, 32'd1);
        check("full_in_ready", {31'b0, io.in_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst          = 1'b0;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        #1;
        check("mrst_out_valid", {31'b0, io.out_valid}, 32'd0);
        check("mrst_c", io.c, 32'd0);
        check("mrst_ovf", {31'b0, io.overflow}, 32'd0);
        check("mrst_in_ready", {31'b0, io.in_ready}, 32'd1);
        step();
        check("mrst_no_ghost", {31'b0, io.out_valid}, 32'd0);
        run_op("after_rst", 32'h0000_0009, 32'h0000_0004, 32'h0000_0005, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
